// File: rtl/tx_uart_cfg_if.sv
// Host-side load interface of the configurable UART transmitter.
interface tx_uart_cfg_if #(
    parameter int unsigned DBIT = 8
);
    logic            i_tx_start;
    logic [DBIT-1:0] i_data;
    logic [1:0]      i_parity_mode;
    logic            o_ready;

    // Host drives the request and payload and observes the holding-register status.
    modport master (
        output i_tx_start,
        output i_data,
        output i_parity_mode,
        input  o_ready
    );

    // Transmitter consumes the request and reports holding-register status.
    modport slave (
        input  i_tx_start,
        input  i_data,
        input  i_parity_mode,
        output o_ready
    );
endinterface

// File: rtl/tx_uart_cfg.sv
// UART transmitter with a one-deep holding register, optional even/odd parity
// and a configurable stop period, paced by an external oversample tick.
module tx_uart_cfg #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned OS_TICK  = 16,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned NB_STATE = 3
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_s_tick,
    tx_uart_cfg_if.slave  host,
    output logic          o_busy,
    output logic          o_tx_done_tick,
    output logic          o_tx
);

    localparam int unsigned TICK_MAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int unsigned TW       = $clog2(TICK_MAX);
    localparam int unsigned BW       = $clog2(DBIT);

    localparam logic [NB_STATE-1:0] ST_IDLE   = NB_STATE'(0);
    localparam logic [NB_STATE-1:0] ST_START  = NB_STATE'(1);
    localparam logic [NB_STATE-1:0] ST_DATA   = NB_STATE'(2);
    localparam logic [NB_STATE-1:0] ST_PARITY = NB_STATE'(3);
    localparam logic [NB_STATE-1:0] ST_STOP   = NB_STATE'(4);

    logic [NB_STATE-1:0] state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DBIT-1:0]     shift_q, shift_d;
    logic                par_q, par_d;
    logic                par_en_q, par_en_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DBIT-1:0]     hold_data_q, hold_data_d;
    logic [1:0]          hold_mode_q, hold_mode_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                accept_c;

    // A start is only taken while the holding register is empty.
    assign accept_c = host.i_tx_start & ready_q;

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic together with counters, shifter and holding register.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        par_en_d     = par_en_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_mode_d  = hold_mode_q;

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    state_d      = ST_START;
                    shift_d      = hold_data_q;
                    par_d        = (^hold_data_q) ^ (hold_mode_q == 2'b10);
                    par_en_d     = (hold_mode_q == 2'b01) || (hold_mode_q == 2'b10);
                    hold_valid_d = 1'b0;
                    tick_d       = '0;
                    bit_d        = '0;
                end
            end
            ST_START: begin
                if (i_s_tick) begin
                    if (tick_q == TW'(OS_TICK - 1)) begin
                        state_d = ST_DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_s_tick) begin
                    if (tick_q == TW'(OS_TICK - 1)) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BW'(DBIT - 1)) begin
                            bit_d   = '0;
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (i_s_tick) begin
                    if (tick_q == TW'(OS_TICK - 1)) begin
                        state_d = ST_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_s_tick) begin
                    if (tick_q == TW'(SB_TICK - 1)) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        // A new accept overrides the transfer-out clear on the same clock.
        if (accept_c) begin
            hold_valid_d = 1'b1;
            hold_data_d  = host.i_data;
            hold_mode_d  = host.i_parity_mode;
        end
    end

    // Output decode; every output is registered so the line lags the state by one clock.
    always_comb begin
        tx_d    = 1'b1;
        busy_d  = (state_d != ST_IDLE);
        ready_d = ~hold_valid_d;
        done_d  = (state_q == ST_STOP) && i_s_tick && (tick_q == TW'(SB_TICK - 1));
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            par_en_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_mode_q  <= 2'b00;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            par_en_q     <= par_en_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_mode_q  <= hold_mode_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_busy         = busy_q;
    assign o_tx_done_tick = done_q;
    assign host.o_ready   = ready_q;

endmodule

// File: tb/tb_tx_uart_cfg.sv
// Bench for tx_uart_cfg: tick-count frame model checked every cycle, plus a
// mid-bit line sampler and hand-computed frame images for directed cases.
module tb_tx_uart_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic s_tick = 1'b0;
    logic busy, done, tx;

    tx_uart_cfg_if #(.DBIT(8)) bus();

    tx_uart_cfg #(
        .DBIT(8), .OS_TICK(16), .SB_TICK(16), .NB_STATE(3)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_s_tick      (s_tick),
        .host          (bus),
        .o_busy        (busy),
        .o_tx_done_tick(done),
        .o_tx          (tx)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Oversample tick: one clock in every ten, gateable for the freeze case.
    bit tick_en = 1'b1;
    int tdiv = 0;
    always @(negedge clk) begin
        if (tick_en) begin
            tdiv   = (tdiv == 9) ? 0 : tdiv + 1;
            s_tick = (tdiv == 0);
        end else begin
            s_tick = 1'b0;
        end
    end

    // Frame model: a frame is a list of line levels, each held for 16 ticks,
    // followed by a 16-tick stop period; the line shows the level for the
    // tick count reached before each clock edge.
    bit         m_valid = 1'b0;
    bit         m_hold_valid;
    logic [7:0] m_hold_data;
    logic [1:0] m_hold_mode;
    bit         m_active;
    int         m_t, m_len, m_nb;
    logic       m_bits [0:9];
    logic       exp_tx, exp_ready, exp_busy, exp_done;
    bit         m_acc;

    function automatic logic level(input int t);
        if (t < 16 * m_nb) return m_bits[t / 16];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hold_valid = 1'b0;
            m_active     = 1'b0;
            m_t          = 0;
            m_nb         = 9;
            exp_tx       = 1'b1;
            exp_ready    = 1'b1;
            exp_busy     = 1'b0;
            exp_done     = 1'b0;
            m_valid      = 1'b1;
        end else begin
            m_acc    = (bus.i_tx_start === 1'b1) && exp_ready;
            exp_tx   = m_active ? level(m_t) : 1'b1;
            exp_done = 1'b0;
            if (m_active) begin
                if (s_tick) begin
                    m_t++;
                    if (m_t == m_len) begin
                        m_active = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end else if (m_hold_valid) begin
                m_nb = (m_hold_mode == 2'b01 || m_hold_mode == 2'b10) ? 10 : 9;
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = m_hold_data[i];
                m_bits[9] = (m_hold_mode == 2'b01) ? ^m_hold_data : ~^m_hold_data;
                m_len        = 16 * m_nb + 16;
                m_active     = 1'b1;
                m_t          = 0;
                m_hold_valid = 1'b0;
            end
            if (m_acc) begin
                m_hold_valid = 1'b1;
                m_hold_data  = bus.i_data;
                m_hold_mode  = bus.i_parity_mode;
            end
            exp_ready = !m_hold_valid;
            exp_busy  = m_active;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",    32'(tx),          32'(exp_tx));
            chk("ready", 32'(bus.o_ready), 32'(exp_ready));
            chk("busy",  32'(busy),        32'(exp_busy));
            chk("done",  32'(done),        32'(exp_done));
        end
    end

    // Event counters used by the directed expectations.
    int done_cnt = 0;
    int busy_ticks = 0;
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rst_n && busy === 1'b1 && s_tick) busy_ticks++;
    end

    // Line sampler: after a falling edge, sample at tick 8 of each 16-tick bit.
    int          exp_nbits = 10;
    bit          s_act = 1'b0;
    int          s_ticks = 0, s_k = 0;
    logic [15:0] s_vec;
    logic [15:0] frames[$];
    always @(posedge clk) begin
        if (!rst_n) begin
            s_act = 1'b0;
        end else if (!s_act) begin
            if (tx === 1'b0) begin
                s_act   = 1'b1;
                s_ticks = 0;
                s_k     = 0;
                s_vec   = '0;
            end
        end else if (s_tick) begin
            s_ticks++;
            if (s_ticks == 8 + 16 * s_k) begin
                s_vec[s_k] = tx;
                s_k++;
                if (s_k == exp_nbits) begin
                    frames.push_back(s_vec);
                    s_act = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        int k = 0;
        while (bus.o_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(bus.o_ready), 32'd1);
        bus.i_tx_start    = 1'b1;
        bus.i_data        = d;
        bus.i_parity_mode = m;
        @(negedge clk);
        bus.i_tx_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output int gap);
        int nd = 0;
        int k  = 0;
        gap = 0;
        while (nd < target && k < budget) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) nd++;
            if (nd == 1 && busy === 1'b0) gap++;
        end
        chk("done_wait", 32'(nd), 32'(target));
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (!(s_act && s_ticks >= n) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("tick_wait", 32'(s_ticks >= n), 32'd1);
    endtask

    task automatic pop_frame(input string name, input logic [15:0] exp);
        logic [15:0] fr;
        chk({name, "_nframes"}, 32'(frames.size() > 0), 32'd1);
        fr = (frames.size() > 0) ? frames.pop_front() : 16'hFFFF;
        chk({name, "_line"}, 32'(fr), 32'(exp));
    endtask

    // Single-frame case: send, wait, then check image, pulse count and length.
    task automatic one_frame(input string name, input logic [7:0] d, input logic [1:0] m,
                             input int nbits, input logic [15:0] img, input int ticks);
        int d0, b0, gap;
        frames.delete();
        exp_nbits = nbits;
        d0 = done_cnt;
        b0 = busy_ticks;
        send(d, m);
        wait_done(1, 4000, gap);
        repeat (20) @(negedge clk);
        pop_frame(name, img);
        chk({name, "_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_ticks"},  32'(busy_ticks - b0), 32'(ticks));
    endtask

    initial begin
        int d0, gap;
        bus.i_tx_start    = 1'b1;
        bus.i_data        = 8'h3C;
        bus.i_parity_mode = 2'b00;

        // Reset held for five clocks with a start request pending.
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tx",    32'(tx),          32'd1);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        rst_n          = 1'b1;
        bus.i_tx_start = 1'b0;
        repeat (300) @(negedge clk);
        chk("rst_no_pulse", 32'(done_cnt), 32'd0);
        chk("rst_no_frame", 32'(frames.size()), 32'd0);
        chk("rst_idle_tx",  32'(tx), 32'd1);

        // Plain, even-parity and odd-parity frames.
        one_frame("aa",     8'hAA, 2'b00, 10, 16'h354, 160);
        one_frame("even07", 8'h07, 2'b01, 11, 16'h60E, 176);
        one_frame("odd07",  8'h07, 2'b10, 11, 16'h40E, 176);
        one_frame("mode11", 8'h07, 2'b11, 10, 16'h20E, 160);

        // Back-to-back frames with a third start ignored while full.
        frames.delete();
        exp_nbits = 10;
        d0 = done_cnt;
        send(8'h55, 2'b00);
        send(8'h0F, 2'b00);
        chk("b2b_full", 32'(bus.o_ready), 32'd0);
        bus.i_tx_start = 1'b1;
        bus.i_data     = 8'hEE;
        repeat (50) @(negedge clk);
        bus.i_tx_start = 1'b0;
        wait_done(2, 6000, gap);
        chk("b2b_gap", 32'(gap), 32'd1);
        repeat (20) @(negedge clk);
        pop_frame("b2b_first",  16'h2AA);
        pop_frame("b2b_second", 16'h21E);
        repeat (2500) @(negedge clk);
        chk("b2b_pulses",  32'(done_cnt - d0), 32'd2);
        chk("b2b_no_more", 32'(frames.size()), 32'd0);
        chk("b2b_ready",   32'(bus.o_ready), 32'd1);

        // Reset during data bit 3 aborts the frame.
        frames.delete();
        d0 = done_cnt;
        send(8'hC3, 2'b00);
        wait_ticks(70);
        chk("abort_bit3", 32'(tx), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_tx",   32'(tx),   32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("abort_no_pulse", 32'(done_cnt - d0), 32'd0);
        chk("abort_ready",    32'(bus.o_ready),   32'd1);
        chk("abort_no_frame", 32'(frames.size()), 32'd0);

        // Tick stalled for 200 clocks during data bit 1, then resumed.
        frames.delete();
        exp_nbits = 10;
        d0 = done_cnt;
        begin
            int b0;
            b0 = busy_ticks;
            send(8'hA5, 2'b00);
            wait_ticks(40);
            chk("freeze_pre", 32'(tx), 32'd0);
            tick_en = 1'b0;
            repeat (200) @(negedge clk);
            chk("freeze_tx",   32'(tx),   32'd0);
            chk("freeze_busy", 32'(busy), 32'd1);
            tick_en = 1'b1;
            wait_done(1, 4000, gap);
            repeat (20) @(negedge clk);
            pop_frame("freeze", 16'h34A);
            chk("freeze_pulses", 32'(done_cnt - d0), 32'd1);
            chk("freeze_ticks",  32'(busy_ticks - b0), 32'd160);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_uart_cfg.md
TX_UART_CFG -- requirements
Module: tx_uart_cfg

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter OS_TICK, default 16, oversample ticks per start/data/parity bit.
REQ-003 The block SHALL have parameter SB_TICK, default 16, ticks in the stop period (16/24/32 = 1/1.5/2 stop bits).
REQ-004 The block SHALL have parameter NB_STATE, default 3, FSM state register width.
REQ-005 The block SHALL have port i_clock  input  1  single system clock, all logic on rising edge.
REQ-006 The block SHALL have port i_reset  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have port i_s_tick  input  1  one-cycle oversample tick from the baudrate generator.
REQ-008 The block SHALL have port i_tx_start  input  1  request to load a frame; valid only while o_ready=1.
REQ-009 The block SHALL have port i_data  input  DBIT  frame payload, LSB sent first.
REQ-010 The block SHALL have port i_parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 The block SHALL have port o_ready  output  1  holding register empty; a start is accepted this cycle.
REQ-012 The block SHALL have port o_busy  output  1  FSM not in IDLE.
REQ-013 The block SHALL have port o_tx_done_tick  output  1  one-cycle pulse at end of each frame's stop period.
REQ-014 The block SHALL have port o_tx  output  1  registered serial line, idle high.

Function
REQ-015 Holding register: i_tx_start=1 with o_ready=1 SHALL latch i_data and i_parity_mode and set hold_valid; o_ready=~hold_valid, registered.
REQ-016 i_tx_start while o_ready=0 SHALL be ignored, with no corruption of the held or in-flight frame.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with hold_valid=1, the next clock SHALL move to START, transfer the held data to the shift register, clear hold_valid, and zero the tick and bit counters; no tick is needed.
REQ-019 If a transfer and a new accept happen on the same clock, the accept SHALL win: hold_valid stays 1 with the new data.
REQ-020 START SHALL drive o_tx=0; on the tick where tick count = OS_TICK-1 it SHALL go to DATA and clear the count.
REQ-021 DATA SHALL drive o_tx=shift[0]; after OS_TICK ticks it SHALL shift right, and at bit count = DBIT-1 go to PARITY (mode 01/10) or STOP (otherwise).
REQ-022 PARITY SHALL drive XOR of the payload bits (even) or its complement (odd) for OS_TICK ticks, then go to STOP.
REQ-023 STOP SHALL drive o_tx=1; on the SB_TICK-th tick it SHALL go to IDLE and assert o_tx_done_tick for exactly that one cycle.
REQ-024 Counters SHALL advance only on clocks with i_s_tick=1; with the tick held low, state and o_tx SHALL freeze.
REQ-025 Tick counter width SHALL be clog2(max(OS_TICK,SB_TICK)); bit counter width SHALL be clog2(DBIT); neither SHALL wrap inside a frame.
REQ-026 o_tx SHALL be a flop; line transitions SHALL occur one clock after the state/counter change that causes them.
REQ-027 Back-to-back frames SHALL be separated by exactly one idle clock (the IDLE->START transfer cycle).

Reset
REQ-028 When i_reset=0 at a rising edge, the block SHALL enter IDLE and set o_tx=1, o_ready=1, o_busy=0, o_tx_done_tick=0, hold_valid=0, and all counters to 0.
REQ-029 Reset mid-frame SHALL abort the frame: no done pulse, held data discarded, line high on the next clock.
REQ-030 While i_reset=0, i_tx_start SHALL be ignored.

Verification (DBIT=8, OS_TICK=16, SB_TICK=16, tick every 10 clocks)
REQ-031 The bench SHALL cover: i_reset=0 for 5 clocks with i_tx_start=1 -> o_tx=1, o_ready=1, o_busy=0, no frame after release.
REQ-032 The bench SHALL cover: 0xAA, mode 00 -> line 0,0,1,0,1,0,1,0,1,1, each bit 16 ticks, one done pulse, o_busy high for 160 ticks.
REQ-033 The bench SHALL cover: 0x07 with mode 01 -> parity bit 1; 0x07 with mode 10 -> parity bit 0; frame 176 ticks.
REQ-034 The bench SHALL cover: accept 0x55, then accept 0x0F while busy, then a third start while o_ready=0 -> exactly two frames 0x55,0x0F separated by one idle clock, and the third byte never sent.
REQ-035 The bench SHALL cover: reset asserted during DATA bit 3 -> o_tx=1 next clock, no done pulse, o_ready=1 after release.
REQ-036 The bench SHALL cover: i_s_tick held low for 200 clocks mid-DATA -> o_tx and state unchanged, and the frame completes correctly once ticks resume.
